// File: rtl/tour_move_sequencer.sv
// Knight's tour replay: turns each L-move into a vertical and a horizontal leg for cmd_proc.
// Optional TOUR_ABORT_EN: a UART opcode 4'hF during a tour aborts it at the next completion.
module tour_move_sequencer #(
    parameter int NUM_MOVES = 24,
    parameter int MV_W      = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_tour,
    input  logic [7:0]      move,
    output logic [MV_W-1:0] mv_indx,
    input  logic [15:0]     cmd_UART,
    input  logic            cmd_rdy_UART,
    input  logic            clr_cmd_rdy,
    input  logic            send_resp,
    output logic [15:0]     cmd,
    output logic            cmd_rdy,
    output logic [7:0]      resp
);

    localparam logic [MV_W-1:0] LAST = MV_W'(NUM_MOVES - 1);

    localparam logic [7:0] HD_N = 8'h00;
    localparam logic [7:0] HD_W = 8'h3F;
    localparam logic [7:0] HD_S = 8'h7F;
    localparam logic [7:0] HD_E = 8'hBF;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

    state_t state, nxt_state;

    logic       tour_act;
    logic       in_hold;
    logic       last_mv;
    logic       abort_now;
    logic [7:0] v_head, h_head;
    logic [3:0] v_sq, h_sq;
    logic [15:0] leg_cmd;

    assign tour_act = (state != IDLE);
    assign in_hold  = (state == HOLD_V) || (state == HOLD_H);
    assign last_mv  = (mv_indx == LAST);

`ifdef TOUR_ABORT_EN
    logic abort_req;

    // Sticky abort request raised by a UART opcode 4'hF while a tour runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            abort_req <= 1'b0;
        else if (abort_now)
            abort_req <= 1'b0;
        else if (tour_act && cmd_rdy_UART && cmd_UART[15:12] == 4'hF)
            abort_req <= 1'b1;
    end

    assign abort_now = abort_req && in_hold && send_resp;
`else
    assign abort_now = 1'b0;
`endif

    // Translate the one-hot move into both legs; illegal values give zero-square legs
    always_comb begin
        v_head = HD_N;
        v_sq   = 4'd0;
        h_head = HD_N;
        h_sq   = 4'd0;
        case (move)
            8'h01: begin v_head = HD_N; v_sq = 4'd2; h_head = HD_E; h_sq = 4'd1; end
            8'h02: begin v_head = HD_N; v_sq = 4'd2; h_head = HD_W; h_sq = 4'd1; end
            8'h04: begin v_head = HD_N; v_sq = 4'd1; h_head = HD_W; h_sq = 4'd2; end
            8'h08: begin v_head = HD_S; v_sq = 4'd1; h_head = HD_W; h_sq = 4'd2; end
            8'h10: begin v_head = HD_S; v_sq = 4'd2; h_head = HD_W; h_sq = 4'd1; end
            8'h20: begin v_head = HD_S; v_sq = 4'd2; h_head = HD_E; h_sq = 4'd1; end
            8'h40: begin v_head = HD_S; v_sq = 4'd1; h_head = HD_E; h_sq = 4'd2; end
            8'h80: begin v_head = HD_N; v_sq = 4'd1; h_head = HD_E; h_sq = 4'd2; end
            default: begin
                v_head = HD_N;
                v_sq   = 4'd0;
                h_head = HD_N;
                h_sq   = 4'd0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    // Move index: cleared whenever the tour ends, bumped after each horizontal leg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mv_indx <= '0;
        else if (nxt_state == IDLE)
            mv_indx <= '0;
        else if (state == HOLD_H && send_resp)
            mv_indx <= mv_indx + 1'b1;
    end

    // Next-state logic for the leg handshake with cmd_proc
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (start_tour) nxt_state = VERT;
            VERT:    if (clr_cmd_rdy) nxt_state = HOLD_V;
            HOLD_V:  if (send_resp) nxt_state = abort_now ? IDLE : HORZ;
            HORZ:    if (clr_cmd_rdy) nxt_state = HOLD_H;
            HOLD_H:  if (send_resp) nxt_state = (last_mv || abort_now) ? IDLE : VERT;
            default: nxt_state = IDLE;
        endcase
    end

    // Command mux and response byte
    always_comb begin
        leg_cmd = {4'h3, h_head, h_sq};
        if (state == VERT || state == HOLD_V)
            leg_cmd = {4'h2, v_head, v_sq};
        cmd     = tour_act ? leg_cmd : cmd_UART;
        cmd_rdy = tour_act ? (state == VERT || state == HORZ) : cmd_rdy_UART;
        resp    = 8'h5A;
        if (!tour_act)
            resp = 8'hA5;
        else if (state == HOLD_H && last_mv)
            resp = 8'hA5;
`ifdef TOUR_ABORT_EN
        else if (abort_req && in_hold)
            resp = 8'hA5;
`endif
    end

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Bench for tour_move_sequencer: randomized tours against a move-table reference model.
module tb_tour_move_sequencer;

    localparam int NUM_MOVES = 24;
    localparam int MV_W      = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_tour;
    logic [7:0]      move;
    logic [MV_W-1:0] mv_indx;
    logic [15:0]     cmd_UART;
    logic            cmd_rdy_UART;
    logic            clr_cmd_rdy;
    logic            send_resp;
    logic [15:0]     cmd;
    logic            cmd_rdy;
    logic [7:0]      resp;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tour_mem [NUM_MOVES];
    int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    tour_move_sequencer #(.NUM_MOVES(NUM_MOVES), .MV_W(MV_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd),
        .cmd_rdy(cmd_rdy), .resp(resp)
    );

    always #5 clk = ~clk;

    // Solver memory model: combinational read at the current index
    always_comb move = (int'(mv_indx) < NUM_MOVES) ? tour_mem[mv_indx] : 8'h00;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2ms", $time);
        $fatal(1);
    end

    task automatic step;
        @(negedge clk);
    endtask

    function automatic bit is_legal(input logic [7:0] m);
        return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
    endfunction

    // Reference: leg from (dx,dy) of the knight move
    function automatic logic [15:0] ref_leg(input logic [7:0] m, input bit horiz);
        int idx, d, mag;
        logic [7:0] hd;
        idx = 0;
        for (int b = 0; b < 8; b++) if (m[b]) idx = b;
        if (!is_legal(m)) return {(horiz ? 4'h3 : 4'h2), 12'h000};
        d   = horiz ? dx_tab[idx] : dy_tab[idx];
        mag = (d < 0) ? -d : d;
        if (horiz) hd = (d > 0) ? 8'hBF : 8'h3F;
        else       hd = (d > 0) ? 8'h00 : 8'h7F;
        return {(horiz ? 4'h3 : 4'h2), hd, 4'(mag)};
    endfunction

    task automatic run_tour(input int abort_move, output int n5a, output int na5,
                            output bit aborted);
        logic [15:0] exp, mask;
        logic [7:0]  exp_resp;
        bit          pend;
        n5a = 0; na5 = 0; aborted = 0; pend = 0;
        start_tour = 1'b1;
        step;
        start_tour = 1'b0;
        for (int k = 0; k < NUM_MOVES; k++) begin
            for (int leg = 0; leg < 2; leg++) begin
                exp  = ref_leg(tour_mem[k], leg[0]);
                mask = is_legal(tour_mem[k]) ? 16'hFFFF : 16'hF00F;
                checks++;
                if (cmd_rdy !== 1'b1 || (cmd & mask) !== (exp & mask)
                    || mv_indx !== MV_W'(k)) begin
                    failures++;
                    $display("FAIL leg_cmd k=%0d leg=%0d: got cmd=%h rdy=%b idx=%0d, required cmd=%h rdy=1 idx=%0d",
                             k, leg, cmd, cmd_rdy, mv_indx, exp, k);
                end
                if (k == abort_move && leg == 0) begin
                    cmd_UART = 16'hF000;
                    cmd_rdy_UART = 1'b1;
                    #1;
                    checks++;
                    if (cmd_rdy !== 1'b1 || (cmd & mask) !== (exp & mask)) begin
                        failures++;
                        $display("FAIL abort_not_fwd: got cmd=%h rdy=%b, required cmd=%h rdy=1",
                                 cmd, cmd_rdy, exp);
                    end
`ifdef TOUR_ABORT_EN
                    pend = 1;
`endif
                    step;
                    cmd_rdy_UART = 1'b0;
                end
                repeat ($urandom_range(0, 2)) begin
                    cmd_UART     = 16'h2005;
                    cmd_rdy_UART = 1'($urandom_range(0, 1));
                    send_resp    = 1'($urandom_range(0, 1));
                    #1;
                    checks++;
                    if (cmd_rdy !== 1'b1 || (cmd & mask) !== (exp & mask)) begin
                        failures++;
                        $display("FAIL active_stall: got cmd=%h rdy=%b, required cmd=%h rdy=1",
                                 cmd, cmd_rdy, exp);
                    end
                    step;
                end
                cmd_rdy_UART = 1'b0;
                clr_cmd_rdy  = 1'b1;
                send_resp    = 1'($urandom_range(0, 1));
                step;
                clr_cmd_rdy  = 1'b0;
                send_resp    = 1'b0;
                checks++;
                if (cmd_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_rdy k=%0d leg=%0d: got rdy=%b, required 0", k, leg, cmd_rdy);
                end
                repeat ($urandom_range(0, 2)) begin
                    clr_cmd_rdy  = 1'($urandom_range(0, 1));
                    cmd_UART     = 16'h2005;
                    cmd_rdy_UART = 1'b1;
                    #1;
                    checks++;
                    if (cmd_rdy !== 1'b0) begin
                        failures++;
                        $display("FAIL hold_ignore: got rdy=%b, required 0", cmd_rdy);
                    end
                    step;
                end
                clr_cmd_rdy  = 1'b0;
                cmd_rdy_UART = 1'b0;
                exp_resp = (pend || (leg == 1 && k == NUM_MOVES - 1)) ? 8'hA5 : 8'h5A;
                send_resp = 1'b1;
                #1;
                checks++;
                if (resp !== exp_resp) begin
                    failures++;
                    $display("FAIL resp k=%0d leg=%0d: got %h, required %h", k, leg, resp, exp_resp);
                end
                if (resp === 8'h5A) n5a++;
                if (resp === 8'hA5) na5++;
                step;
                send_resp = 1'b0;
                if (pend) begin
                    aborted = 1;
                    return;
                end
            end
        end
    endtask

    task automatic check_idle(input string tag);
        logic [15:0] u;
        u = 16'($urandom);
        cmd_UART = u;
        cmd_rdy_UART = 1'b1;
        #1;
        checks++;
        if (mv_indx !== '0 || cmd !== u || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
            failures++;
            $display("FAIL %s: got idx=%0d cmd=%h rdy=%b resp=%h, required idx=0 cmd=%h rdy=1 resp=a5",
                     tag, mv_indx, cmd, cmd_rdy, resp, u);
        end
        cmd_rdy_UART = 1'b0;
        step;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1;
        for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'h00;
        #12;
        checks++;
        if (mv_indx !== '0 || cmd !== 16'h2003 || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
            failures++;
            $display("FAIL reset: got idx=%0d cmd=%h rdy=%b resp=%h, required 0 2003 1 a5",
                     mv_indx, cmd, cmd_rdy, resp);
        end
        step;
        rst_n = 1'b1;
        step;
        check_idle("idle_after_reset");
    endtask

    task automatic test_passthrough;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] u;
            logic        r;
            u = 16'($urandom);
            r = 1'($urandom_range(0, 1));
            cmd_UART = u;
            cmd_rdy_UART = r;
            #1;
            checks++;
            if (cmd !== u || cmd_rdy !== r) begin
                failures++;
                $display("FAIL passthrough: got cmd=%h rdy=%b, required %h %b", cmd, cmd_rdy, u, r);
            end
            step;
        end
        cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_known_moves;
        tour_mem[0] = 8'h20;
        tour_mem[1] = 8'h04;
        start_tour = 1'b1; step; start_tour = 1'b0;
        checks++;
        if (cmd !== 16'h27F2 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL b5_vert: got %h rdy=%b, required 27f2 rdy=1", cmd, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1; step; clr_cmd_rdy = 1'b0;
        send_resp = 1'b1; #1;
        checks++;
        if (resp !== 8'h5A) begin
            failures++;
            $display("FAIL b5_resp: got %h, required 5a", resp);
        end
        step; send_resp = 1'b0;
        checks++;
        if (cmd !== 16'h3BF1 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL b5_horz: got %h rdy=%b, required 3bf1 rdy=1", cmd, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1; step; clr_cmd_rdy = 1'b0;
        send_resp = 1'b1; step; send_resp = 1'b0;
        checks++;
        if (cmd !== 16'h2001 || mv_indx !== MV_W'(1)) begin
            failures++;
            $display("FAIL b2_vert: got %h idx=%0d, required 2001 idx=1", cmd, mv_indx);
        end
        clr_cmd_rdy = 1'b1; step; clr_cmd_rdy = 1'b0;
        send_resp = 1'b1; step; send_resp = 1'b0;
        start_tour = 1'b1; step; start_tour = 1'b0;
        checks++;
        if (cmd !== 16'h33F2 || cmd_rdy !== 1'b1 || mv_indx !== MV_W'(1)) begin
            failures++;
            $display("FAIL b2_horz: got %h rdy=%b idx=%0d, required 33f2 rdy=1 idx=1",
                     cmd, cmd_rdy, mv_indx);
        end
        #2 rst_n = 1'b0;
        cmd_rdy_UART = 1'b0;
        #1;
        checks++;
        if (mv_indx !== '0 || cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
            failures++;
            $display("FAIL async_reset: got idx=%0d rdy=%b resp=%h, required 0 0 a5",
                     mv_indx, cmd_rdy, resp);
        end
        step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_full_tour;
        int n5a, na5;
        bit ab;
        for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'h01 << $urandom_range(0, 7);
        run_tour(-1, n5a, na5, ab);
        checks++;
        if (n5a != 47 || na5 != 1) begin
            failures++;
            $display("FAIL tour_resp_count: got 5a=%0d a5=%0d, required 47 1", n5a, na5);
        end
        check_idle("idle_after_tour");
    endtask

    task automatic test_back_to_back;
        int n5a, na5;
        bit ab;
        for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'h01 << $urandom_range(0, 7);
        run_tour(-1, n5a, na5, ab);
        for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'h01 << $urandom_range(0, 7);
        run_tour(-1, n5a, na5, ab);
        checks++;
        if (n5a != 47 || na5 != 1) begin
            failures++;
            $display("FAIL b2b_resp_count: got 5a=%0d a5=%0d, required 47 1", n5a, na5);
        end
        check_idle("idle_after_b2b");
    endtask

    task automatic test_illegal;
        int n5a, na5;
        bit ab;
        for (int i = 0; i < NUM_MOVES; i++) begin
            case ($urandom_range(0, 3))
                0:       tour_mem[i] = 8'h00;
                1:       tour_mem[i] = 8'hC3;
                default: tour_mem[i] = 8'h01 << $urandom_range(0, 7);
            endcase
        end
        tour_mem[2] = 8'h00;
        tour_mem[5] = 8'h81;
        run_tour(-1, n5a, na5, ab);
        checks++;
        if (n5a != 47 || na5 != 1) begin
            failures++;
            $display("FAIL illegal_resp_count: got 5a=%0d a5=%0d, required 47 1", n5a, na5);
        end
        check_idle("idle_after_illegal");
    endtask

    task automatic test_abort;
        int n5a, na5;
        bit ab;
        for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'h01 << $urandom_range(0, 7);
        run_tour(3, n5a, na5, ab);
        checks++;
`ifdef TOUR_ABORT_EN
        if (ab != 1 || n5a != 6 || na5 != 1) begin
            failures++;
            $display("FAIL abort: got aborted=%0d 5a=%0d a5=%0d, required 1 6 1", ab, n5a, na5);
        end
`else
        if (ab != 0 || n5a != 47 || na5 != 1) begin
            failures++;
            $display("FAIL no_abort: got aborted=%0d 5a=%0d a5=%0d, required 0 47 1", ab, n5a, na5);
        end
`endif
        check_idle("idle_after_abort");
    endtask

    initial begin
        test_reset;
        test_passthrough;
        test_known_moves;
        check_idle("idle_after_async_reset");
        test_full_tour;
        test_illegal;
        test_abort;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
